cc_matrix_stream: RTL and testbench

CC_MATRIX_STREAM -- requirements
Module: cc_matrix_stream

---
 rtl/cc_matrix_stream.sv | 219 +++++++++++++++++++++
 tb/tb_cc_matrix_stream.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_matrix_stream.sv
// Colour-correction matrix over an AXI4-Stream video bus.
// Each output channel is a signed fixed-point weighted sum of the input
// channels plus an offset, rounded and clipped to the pixel range.
// Coefficients are double-banked: writes go to a shadow bank that is copied
// to the active bank only on a start-of-frame beat, so a frame never mixes
// two coefficient sets. Four-stage pipeline, all stages share one enable.
module cc_matrix_stream #(
    parameter int PX_WIDTH    = 10,
    parameter int CH_NUM      = 3,
    parameter int INT_WIDTH   = 3,
    parameter int FRACT_WIDTH = 10,
    localparam int COEF_WIDTH  = 1 + INT_WIDTH + FRACT_WIDTH,
    localparam int TDATA_WIDTH = ((CH_NUM * PX_WIDTH + 7) / 8) * 8
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   coef_wr_i,
    input  logic [4:0]             coef_sel_i,
    input  logic [COEF_WIDTH-1:0]  coef_data_i,
    input  logic                   coef_commit_i,
    output logic                   commit_pending_o,
    input  logic                   bypass_i,
    input  logic [TDATA_WIDTH-1:0] video_i_tdata,
    input  logic                   video_i_tvalid,
    output logic                   video_i_tready,
    input  logic                   video_i_tlast,
    input  logic                   video_i_tuser,
    output logic [TDATA_WIDTH-1:0] video_o_tdata,
    output logic                   video_o_tvalid,
    input  logic                   video_o_tready,
    output logic                   video_o_tlast,
    output logic                   video_o_tuser
);

    localparam int ROW      = CH_NUM + 1;
    localparam int NUM_COEF = CH_NUM * ROW;
    localparam int IDX_W    = $clog2(NUM_COEF);
    // Product of a signed coefficient and a zero-extended pixel.
    localparam int PROD_W   = COEF_WIDTH + PX_WIDTH + 1;
    // Up to five terms (four products plus offset) need three guard bits.
    localparam int ACC_W    = PROD_W + 3;

    localparam logic [5:0]                    SEL_LIMIT  = 6'(NUM_COEF);
    localparam logic signed [COEF_WIDTH-1:0]  COEF_ONE   = COEF_WIDTH'(1 << FRACT_WIDTH);
    localparam logic signed [ACC_W-1:0]       ROUND_HALF = ACC_W'(1 << (FRACT_WIDTH - 1));
    localparam logic signed [ACC_W-1:0]       PX_MAX_S   = ACC_W'((1 << PX_WIDTH) - 1);

    logic signed [COEF_WIDTH-1:0] shadow_bank [NUM_COEF];
    logic signed [COEF_WIDTH-1:0] active_bank [NUM_COEF];
    logic signed [COEF_WIDTH-1:0] eff_bank    [NUM_COEF];
    logic                         commit_pending;

    logic                enable;
    logic                accept;
    logic                sof_load;
    logic                coef_sel_ok;
    logic [PX_WIDTH-1:0] in_px [CH_NUM];
    logic                unused_pad;

    // Stage 1: products and offsets
    logic                     valid1, user1, last1, byp1;
    logic [PX_WIDTH-1:0]      px1   [CH_NUM];
    logic signed [PROD_W-1:0] prod1 [CH_NUM][CH_NUM];
    logic signed [COEF_WIDTH-1:0] off1 [CH_NUM];

    // Stage 2: full-precision sums
    logic                    valid2, user2, last2, byp2;
    logic [PX_WIDTH-1:0]     px2     [CH_NUM];
    logic signed [ACC_W-1:0] acc_sum [CH_NUM];
    logic signed [ACC_W-1:0] acc2    [CH_NUM];

    // Stage 3: rounded, clipped or bypassed pixels
    logic                    valid3, user3, last3;
    logic signed [ACC_W-1:0] rounded [CH_NUM];
    logic [PX_WIDTH-1:0]     res_px  [CH_NUM];
    logic [PX_WIDTH-1:0]     res3    [CH_NUM];

    // Stage 4: output register
    logic [PX_WIDTH-1:0] out_px [CH_NUM];

    assign enable           = !video_o_tvalid || video_o_tready;
    assign video_i_tready   = enable;
    assign accept           = video_i_tvalid && enable;
    assign sof_load         = accept && video_i_tuser && (commit_pending || coef_commit_i);
    assign coef_sel_ok      = {1'b0, coef_sel_i} < SEL_LIMIT;
    assign commit_pending_o = commit_pending;
    // Padding bits above the packed channels carry no meaning.
    assign unused_pad       = ^video_i_tdata;

    // Unpack input channels and pick the bank this beat will use
    always_comb begin
        for (int k = 0; k < CH_NUM; k++) begin
            in_px[k] = video_i_tdata[k*PX_WIDTH +: PX_WIDTH];
        end
        for (int i = 0; i < NUM_COEF; i++) begin
            eff_bank[i] = sof_load ? shadow_bank[i] : active_bank[i];
        end
    end

    // Coefficient banks and commit handshake; same-cycle shadow write misses the copy
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_COEF; i++) begin
                shadow_bank[i] <= ((i % ROW) == (i / ROW)) ? COEF_ONE : '0;
                active_bank[i] <= ((i % ROW) == (i / ROW)) ? COEF_ONE : '0;
            end
            commit_pending <= 1'b0;
        end else begin
            if (sof_load) begin
                active_bank    <= shadow_bank;
                commit_pending <= 1'b0;
            end else if (coef_commit_i) begin
                commit_pending <= 1'b1;
            end
            if (coef_wr_i && coef_sel_ok) begin
                shadow_bank[coef_sel_i[IDX_W-1:0]] <= coef_data_i;
            end
        end
    end

    // Stage 1: multiply every pixel by its coefficient, capture offsets
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            valid1 <= 1'b0;
        end else if (enable) begin
            valid1 <= accept;
            user1  <= video_i_tuser;
            last1  <= video_i_tlast;
            byp1   <= bypass_i;
            for (int c = 0; c < CH_NUM; c++) begin
                px1[c]  <= in_px[c];
                off1[c] <= eff_bank[c*ROW + CH_NUM];
                for (int k = 0; k < CH_NUM; k++) begin
                    prod1[c][k] <= PROD_W'(eff_bank[c*ROW + k]) *
                                   PROD_W'($signed({1'b0, in_px[k]}));
                end
            end
        end
    end

    // Sum products and offset per output channel
    always_comb begin
        for (int c = 0; c < CH_NUM; c++) begin
            acc_sum[c] = ACC_W'(off1[c]);
            for (int k = 0; k < CH_NUM; k++) begin
                acc_sum[c] = acc_sum[c] + ACC_W'(prod1[c][k]);
            end
        end
    end

    // Stage 2: register the sums
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            valid2 <= 1'b0;
        end else if (enable) begin
            valid2 <= valid1;
            user2  <= user1;
            last2  <= last1;
            byp2   <= byp1;
            for (int c = 0; c < CH_NUM; c++) begin
                px2[c]  <= px1[c];
                acc2[c] <= acc_sum[c];
            end
        end
    end

    // Round half up, drop the fraction, clip to pixel range, or bypass
    always_comb begin
        for (int c = 0; c < CH_NUM; c++) begin
            rounded[c] = (acc2[c] + ROUND_HALF) >>> FRACT_WIDTH;
            if (byp2) begin
                res_px[c] = px2[c];
            end else if (rounded[c] < 0) begin
                res_px[c] = '0;
            end else if (rounded[c] > PX_MAX_S) begin
                res_px[c] = '1;
            end else begin
                res_px[c] = rounded[c][PX_WIDTH-1:0];
            end
        end
    end

    // Stage 3: register the final pixel values
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            valid3 <= 1'b0;
        end else if (enable) begin
            valid3 <= valid2;
            user3  <= user2;
            last3  <= last2;
            for (int c = 0; c < CH_NUM; c++) begin
                res3[c] <= res_px[c];
            end
        end
    end

    // Stage 4: output register, held while the sink stalls
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            video_o_tvalid <= 1'b0;
        end else if (enable) begin
            video_o_tvalid <= valid3;
            video_o_tuser  <= user3;
            video_o_tlast  <= last3;
            for (int c = 0; c < CH_NUM; c++) begin
                out_px[c] <= res3[c];
            end
        end
    end

    // Pack output channels, padding bits forced to zero
    always_comb begin
        video_o_tdata = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            video_o_tdata[c*PX_WIDTH +: PX_WIDTH] = out_px[c];
        end
    end

endmodule

// File: tb/tb_cc_matrix_stream.sv
// Testbench for cc_matrix_stream (10-bit pixels, 3 channels, 3.10 coefficients).
// A reference model tracks coefficient banks and the commit flag, predicts
// every output beat with plain integer arithmetic, and a per-cycle monitor
// compares the DUT against it. Directed scenarios add literal expectations.
module tb_cc_matrix_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        coef_wr;
    logic [4:0]  coef_sel;
    logic [13:0] coef_data;
    logic        coef_commit;
    logic        commit_pending;
    logic        bypass;
    logic [31:0] in_tdata;
    logic        in_tvalid, in_tready, in_tlast, in_tuser;
    logic [31:0] out_tdata;
    logic        out_tvalid, out_tready, out_tlast, out_tuser;

    typedef struct {
        logic [31:0] data;
        logic        user;
        logic        last;
        int          acc_cyc;
        int          acc_frz;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] got_data [$];
    logic        got_user [$];
    int          sh_m [12];
    int          ac_m [12];
    bit          pend_m;
    bit          front_seen;
    int          cyc = 0;
    int          frz = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    cc_matrix_stream #(
        .PX_WIDTH(10), .CH_NUM(3), .INT_WIDTH(3), .FRACT_WIDTH(10)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .coef_wr_i(coef_wr),
        .coef_sel_i(coef_sel),
        .coef_data_i(coef_data),
        .coef_commit_i(coef_commit),
        .commit_pending_o(commit_pending),
        .bypass_i(bypass),
        .video_i_tdata(in_tdata),
        .video_i_tvalid(in_tvalid),
        .video_i_tready(in_tready),
        .video_i_tlast(in_tlast),
        .video_i_tuser(in_tuser),
        .video_o_tdata(out_tdata),
        .video_o_tvalid(out_tvalid),
        .video_o_tready(out_tready),
        .video_o_tlast(out_tlast),
        .video_o_tuser(out_tuser)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] pack3(input int a, input int b, input int c);
        logic [31:0] w;
        w = '0;
        w[9:0]   = a[9:0];
        w[19:10] = b[9:0];
        w[29:20] = c[9:0];
        return w;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 12; i++) begin
            sh_m[i] = ((i % 4) == (i / 4)) ? 1024 : 0;
            ac_m[i] = sh_m[i];
        end
        pend_m     = 1'b0;
        front_seen = 1'b0;
        exp_q.delete();
    endfunction

    // out_c = clip(floor((sum_k a[c][k]*in_k + o[c] + 0.5*1024) / 1024))
    function automatic logic [31:0] expected_pixel(input bit use_shadow, input logic [31:0] din, input bit byp);
        logic [31:0] w;
        int          bank [12];
        longint      s;
        longint      q;
        int          v;
        w = '0;
        bank = use_shadow ? sh_m : ac_m;
        for (int c = 0; c < 3; c++) begin
            if (byp) begin
                v = int'(din[c*10 +: 10]);
            end else begin
                s = longint'(bank[c*4 + 3]);
                for (int k = 0; k < 3; k++) begin
                    s = s + longint'(bank[c*4 + k]) * longint'(din[k*10 +: 10]);
                end
                q = (s + 512) >>> 10;
                v = (q < 0) ? 0 : (q > 1023) ? 1023 : int'(q);
            end
            w[c*10 +: 10] = v[9:0];
        end
        return w;
    endfunction

    // Monitor: compare outputs against the model, then advance the model for the coming edge
    always @(negedge clk) begin
        exp_t e;
        bit   use_new;
        int   elapsed;
        if (!rst_n) begin
            model_reset();
        end else begin
            checkOutput("commit_pending", commit_pending, pend_m);
            checkOutput("in_ready", in_tready, !out_tvalid || out_tready);
            if (exp_q.size() > 0) begin
                elapsed = cyc - exp_q[0].acc_cyc - (frz - exp_q[0].acc_frz);
                if (out_tvalid) begin
                    if (!front_seen) begin
                        checkOutput("latency", elapsed, 4);
                        front_seen = 1'b1;
                    end
                    checkOutput("out_tdata", out_tdata, exp_q[0].data);
                    checkOutput("out_tuser", out_tuser, exp_q[0].user);
                    checkOutput("out_tlast", out_tlast, exp_q[0].last);
                end else if (elapsed >= 4) begin
                    checkOutput("out_tvalid", out_tvalid, 1);
                end
            end else if (out_tvalid) begin
                checks++;
                errors++;
                $display("[TB] FAIL spurious_beat: actual tvalid=1 tdata=%h, required tvalid=0", out_tdata);
            end
            if (out_tvalid && out_tready) begin
                got_data.push_back(out_tdata);
                got_user.push_back(out_tuser);
                if (exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    front_seen = 1'b0;
                end
            end
            use_new = 1'b0;
            if (in_tvalid && in_tready) begin
                use_new   = in_tuser && (pend_m || coef_commit);
                e.data    = expected_pixel(use_new, in_tdata, bypass);
                e.user    = in_tuser;
                e.last    = in_tlast;
                e.acc_cyc = cyc;
                e.acc_frz = frz;
                exp_q.push_back(e);
            end
            if (use_new) begin
                ac_m   = sh_m;
                pend_m = 1'b0;
            end else if (coef_commit) begin
                pend_m = 1'b1;
            end
            if (coef_wr && coef_sel < 5'd12) begin
                sh_m[coef_sel] = int'($signed(coef_data));
            end
            if (out_tvalid && !out_tready) begin
                frz++;
            end
        end
        cyc++;
    end

    // Drive one beat and hold it until accepted; sideband pulses last one cycle
    task automatic applyStimulus(input int p0, input int p1, input int p2,
                                 input bit sof, input bit eol, input bit byp);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        in_tdata  = {2'b11, 10'(p2), 10'(p1), 10'(p0)};
        in_tvalid = 1'b1;
        in_tuser  = sof;
        in_tlast  = eol;
        bypass    = byp;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_tready;
            @(posedge clk);
            #1;
            coef_commit = 1'b0;
            coef_wr     = 1'b0;
            n++;
        end
        in_tvalid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: actual not accepted, required accepted within 100 cycles");
        end
    endtask

    task automatic writeCoef(input int sel, input int data);
        coef_wr   = 1'b1;
        coef_sel  = 5'(sel);
        coef_data = 14'(data);
        @(posedge clk);
        #1;
        coef_wr = 1'b0;
    endtask

    task automatic commitPulse();
        coef_commit = 1'b1;
        @(posedge clk);
        #1;
        coef_commit = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while ((exp_q.size() != 0 || out_tvalid) && n < 100);
        if (n >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: actual %0d beats outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual time limit reached, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        rst_n       = 1'b0;
        coef_wr     = 1'b0;
        coef_sel    = '0;
        coef_data   = '0;
        coef_commit = 1'b0;
        bypass      = 1'b0;
        in_tdata    = '0;
        in_tvalid   = 1'b0;
        in_tlast    = 1'b0;
        in_tuser    = 1'b0;
        out_tready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("rst_out_tvalid", out_tvalid, 0);
        checkOutput("rst_in_ready", in_tready, 1);
        checkOutput("rst_pending", commit_pending, 0);

        $display("[TB] identity pass-through of an SOF beat");
        base = got_data.size();
        applyStimulus(100, 200, 300, 1, 0, 0);
        drain();
        checkOutput("identity_data", got_data[base], pack3(100, 200, 300));
        checkOutput("identity_tuser", got_user[base], 1);

        $display("[TB] gain 2.0 saturates, offset -8.0 clips to zero");
        writeCoef(0, 2048);
        writeCoef(7, -8192);
        commitPulse();
        checkOutput("pending_set", commit_pending, 1);
        base = got_data.size();
        applyStimulus(600, 5, 300, 1, 0, 0);
        applyStimulus(600, 100, 7, 0, 1, 0);
        drain();
        checkOutput("sat_high", got_data[base], pack3(1023, 0, 300));
        checkOutput("offset_sub", got_data[base+1], pack3(1023, 92, 7));
        checkOutput("pending_cleared", commit_pending, 0);

        $display("[TB] gain 0.5 rounding and bypass");
        writeCoef(0, 512);
        writeCoef(7, 0);
        commitPulse();
        base = got_data.size();
        applyStimulus(3, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(5, 0, 0, 0, 0, 0);
        applyStimulus(600, 700, 800, 0, 1, 1);
        drain();
        checkOutput("round_1p5", got_data[base], pack3(2, 0, 0));
        checkOutput("round_0p5", got_data[base+1], pack3(1, 0, 0));
        checkOutput("round_2p5", got_data[base+2], pack3(3, 0, 0));
        checkOutput("bypass", got_data[base+3], pack3(600, 700, 800));

        $display("[TB] commit mid-frame waits for next SOF");
        writeCoef(0, 3072);
        base = got_data.size();
        for (int i = 0; i < 10; i++) begin
            if (i == 5) coef_commit = 1'b1;
            applyStimulus(10 + i, i, 2 * i, i == 0, i == 9, 0);
        end
        checkOutput("pending_mid_frame", commit_pending, 1);
        coef_wr   = 1'b1;
        coef_sel  = 5'd0;
        coef_data = 14'd1024;
        applyStimulus(10, 1, 2, 1, 1, 0);
        checkOutput("pending_after_sof", commit_pending, 0);
        applyStimulus(10, 1, 2, 1, 1, 0);
        coef_commit = 1'b1;
        applyStimulus(10, 1, 2, 1, 1, 0);
        drain();
        checkOutput("old_bank_px5", got_data[base+5], pack3(8, 5, 10));
        checkOutput("old_bank_px9", got_data[base+9], pack3(10, 9, 18));
        checkOutput("new_bank_sof", got_data[base+10], pack3(30, 1, 2));
        checkOutput("late_write_excluded", got_data[base+11], pack3(30, 1, 2));
        checkOutput("commit_with_sof", got_data[base+12], pack3(10, 1, 2));

        $display("[TB] back-pressure over a 20-beat stream");
        base = got_data.size();
        fork
            begin
                for (int i = 1; i <= 20; i++) begin
                    applyStimulus(i, i, i, i == 1, i == 20, 0);
                end
            end
            begin
                repeat (8) begin
                    @(posedge clk);
                    #1;
                end
                out_tready = 1'b0;
                #1;
                checkOutput("stall_in_ready", in_tready, 0);
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                out_tready = 1'b1;
            end
        join
        drain();
        checkOutput("stream_count", got_data.size() - base, 20);
        for (int i = 0; i < 20; i++) begin
            checkOutput("stream_order", got_data[base+i], pack3(i + 1, i + 1, i + 1));
        end

        $display("[TB] reset mid-frame");
        writeCoef(0, 2048);
        commitPulse();
        applyStimulus(100, 1, 2, 1, 0, 0);
        commitPulse();
        applyStimulus(101, 1, 2, 0, 0, 0);
        applyStimulus(102, 1, 2, 0, 0, 0);
        applyStimulus(103, 1, 2, 0, 0, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("mid_rst_tvalid", out_tvalid, 0);
        checkOutput("mid_rst_pending", commit_pending, 0);
        checkOutput("mid_rst_in_ready", in_tready, 1);
        base = got_data.size();
        applyStimulus(50, 60, 70, 1, 1, 0);
        drain();
        checkOutput("post_rst_count", got_data.size() - base, 1);
        checkOutput("post_rst_identity", got_data[base], pack3(50, 60, 70));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
